regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two one-entry request buffers sharing a registered register-file write port.
// Optional macro WB_HAZARD_CHECK_EN builds the pending-write compare for the two read ports.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              hazard1,
   output logic              hazard2
);

   typedef enum logic {GRANT_A, GRANT_B} grant_e;

   grant_e            lastGrant;
   logic              bufAValid;
   logic [ADDR_W-1:0] bufAAddr;
   logic [DATA_W-1:0] bufAData;
   logic              bufBValid;
   logic [ADDR_W-1:0] bufBAddr;
   logic [DATA_W-1:0] bufBData;
   logic              grantA;
   logic              grantB;
   logic              acceptA;
   logic              acceptB;

   // Ties go to whichever requester was not served last.
   always_comb begin
      grantA = bufAValid && (!bufBValid || lastGrant == GRANT_B);
      grantB = bufBValid && (!bufAValid || lastGrant == GRANT_A);
   end

   assign a_ready = !bufAValid || grantA;
   assign b_ready = !bufBValid || grantB;
   assign acceptA = a_valid && a_ready;
   assign acceptB = b_valid && b_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bufAValid <= 1'b0;
         bufAAddr  <= '0;
         bufAData  <= '0;
      end else if (acceptA) begin
         bufAValid <= 1'b1;
         bufAAddr  <= a_addr;
         bufAData  <= a_data;
      end else if (grantA) begin
         bufAValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bufBValid <= 1'b0;
         bufBAddr  <= '0;
         bufBData  <= '0;
      end else if (acceptB) begin
         bufBValid <= 1'b1;
         bufBAddr  <= b_addr;
         bufBData  <= b_data;
      end else if (grantB) begin
         bufBValid <= 1'b0;
      end
   end

   // Address 0 still consumes the slot, it just never asserts the write strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
         lastGrant <= GRANT_B;
      end else if (grantA) begin
         RegWrite  <= (bufAAddr != '0);
         WriteReg  <= bufAAddr;
         WriteData <= bufAData;
         lastGrant <= GRANT_A;
      end else if (grantB) begin
         RegWrite  <= (bufBAddr != '0);
         WriteReg  <= bufBAddr;
         WriteData <= bufBData;
         lastGrant <= GRANT_B;
      end else begin
         RegWrite  <= 1'b0;
      end
   end

`ifdef WB_HAZARD_CHECK_EN
   always_comb begin
      hazard1 = (rd_addr1 != '0) &&
                ((bufAValid && bufAAddr == rd_addr1) ||
                 (bufBValid && bufBAddr == rd_addr1) ||
                 (RegWrite  && WriteReg == rd_addr1));
      hazard2 = (rd_addr2 != '0) &&
                ((bufAValid && bufAAddr == rd_addr2) ||
                 (bufBValid && bufBAddr == rd_addr2) ||
                 (RegWrite  && WriteReg == rd_addr2));
   end
`else
   logic unusedRdAddr;
   assign unusedRdAddr = ^{rd_addr1, rd_addr2};
   assign hazard1      = 1'b0;
   assign hazard2      = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a queue-based transaction model.
// Hazard expectations follow WB_HAZARD_CHECK_EN the same way the design does.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [4:0]  rd_addr1, rd_addr2;
   logic        hazard1, hazard2;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } beat_t;

   // Model: each requester holds at most one pending beat; aServedLast remembers the last winner.
   beat_t       qA[$];
   beat_t       qB[$];
   bit          aServedLast;
   logic        expRegWrite;
   logic [4:0]  expWriteReg;
   logic [31:0] expWriteData;

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      qA.delete();
      qB.delete();
      aServedLast  = 1'b0;
      expRegWrite  = 1'b0;
      expWriteReg  = '0;
      expWriteData = '0;
   endtask

   function automatic bit expHazard(input logic [4:0] rd);
`ifdef WB_HAZARD_CHECK_EN
      bit hit = 1'b0;
      if (rd == 0) return 1'b0;
      foreach (qA[i]) if (qA[i].addr == rd) hit = 1'b1;
      foreach (qB[i]) if (qB[i].addr == rd) hit = 1'b1;
      if (expRegWrite && expWriteReg == rd) hit = 1'b1;
      return hit;
`else
      return (rd == 5'h1F) && (rd == 5'h0);
`endif
   endfunction

   // Entered just after a falling edge; leaves at the next falling edge.
   task automatic doCycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                          input logic [4:0] r1, input logic [4:0] r2,
                          output bit aTook, output bit bTook);
      bit    aWins, bWins, expARdy, expBRdy;
      beat_t beat;
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      rd_addr1 = r1; rd_addr2 = r2;
      aWins   = (qA.size() != 0) && ((qB.size() == 0) || !aServedLast);
      bWins   = (qB.size() != 0) && ((qA.size() == 0) || aServedLast);
      expARdy = (qA.size() == 0) || aWins;
      expBRdy = (qB.size() == 0) || bWins;
      #1;
      checkVal("a_ready", a_ready, expARdy);
      checkVal("b_ready", b_ready, expBRdy);
      checkVal("hazard1", hazard1, expHazard(r1));
      checkVal("hazard2", hazard2, expHazard(r2));
      if (aWins) begin
         beat = qA.pop_front();
         aServedLast = 1'b1;
      end else if (bWins) begin
         beat = qB.pop_front();
         aServedLast = 1'b0;
      end
      if (aWins || bWins) begin
         expRegWrite  = (beat.addr != 0);
         expWriteReg  = beat.addr;
         expWriteData = beat.data;
      end else begin
         expRegWrite = 1'b0;
      end
      aTook = av && expARdy;
      bTook = bv && expBRdy;
      if (aTook) qA.push_back('{addr: aa, data: ad});
      if (bTook) qB.push_back('{addr: ba, data: bd});
      @(posedge clk);
      #1;
      checkVal("RegWrite", RegWrite, expRegWrite);
      checkVal("WriteReg", WriteReg, expWriteReg);
      checkVal("WriteData", WriteData, expWriteData);
      @(negedge clk);
   endtask

   task automatic idleCycle();
      bit ta, tb2;
      doCycle(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, ta, tb2);
   endtask

   initial begin
      bit          ta, tb2;
      logic [4:0]  nextA, nextB;
      reset_n = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      rd_addr1 = '0; rd_addr2 = '0;
      modelReset();
      #3;
      checkVal("rst_RegWrite", RegWrite, 1'b0);
      checkVal("rst_WriteReg", WriteReg, 5'd0);
      checkVal("rst_WriteData", WriteData, 32'd0);
      checkVal("rst_a_ready", a_ready, 1'b1);
      checkVal("rst_b_ready", b_ready, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;

      // Single A beat: on the port one cycle after acceptance.
      doCycle(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, '0, '0, ta, tb2);
      checkVal("a3_accept", ta, 1'b1);
      checkVal("a3_b_ready", b_ready, 1'b1);
      idleCycle();
      checkVal("a3_RegWrite", RegWrite, 1'b1);
      checkVal("a3_WriteReg", WriteReg, 5'd3);
      checkVal("a3_WriteData", WriteData, 32'h11);
      idleCycle();

      // Both streaming: addresses advance only when a beat is accepted.
      nextA = 5'd1;
      nextB = 5'd17;
      for (int i = 0; i < 12; i++) begin
         doCycle(1'b1, nextA, 32'hA000_0000 + 32'(nextA), 1'b1, nextB, 32'hB000_0000 + 32'(nextB),
                 nextB, 5'd0, ta, tb2);
         if (ta) nextA++;
         if (tb2) nextB++;
      end
      for (int i = 0; i < 3; i++) idleCycle();

      // Address 0 beat: handshake completes, no write strobe.
      doCycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, '0, '0, ta, tb2);
      checkVal("zero_accept", ta, 1'b1);
      idleCycle();
      checkVal("zero_RegWrite", RegWrite, 1'b0);
      checkVal("zero_WriteData", WriteData, 32'hFFFF_FFFF);

      // Contention with B holding addr 9 while rd_addr1 watches it.
      doCycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0, ta, tb2);
      doCycle(1'b1, 5'd5, 32'h55, 1'b0, '0, '0, 5'd9, 5'd0, ta, tb2);
      doCycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0, ta, tb2);
      doCycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0, ta, tb2);
      doCycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0, ta, tb2);

      // Randomized traffic with small address range to exercise zero and hazard cases.
      for (int i = 0; i < 400; i++) begin
         doCycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ta, tb2);
      end

      // Mid-operation reset with both buffers loaded.
      doCycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, '0, '0, ta, tb2);
      a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
      b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAA;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkVal("mid_rst_RegWrite", RegWrite, 1'b0);
      checkVal("mid_rst_WriteReg", WriteReg, 5'd0);
      checkVal("mid_rst_WriteData", WriteData, 32'd0);
      modelReset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) idleCycle();

      for (int i = 0; i < 200; i++) begin
         doCycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ta, tb2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
